// File: rtl/ps2_scancode_rx_pkg.sv
// ps2_scancode_rx_pkg: frame states and PS/2 protocol constants shared by the receiver
package ps2_scancode_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam int         FRAME_BITS = 11;

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: bit-level PS/2 receiver producing one byte per valid 11-bit frame
module ps2_frame_rx
    import ps2_scancode_rx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]   clk_sync;
    logic [1:0]   data_sync;
    logic         clk_prev;
    logic         fall;
    logic         din;
    logic         timeout;
    frame_state_t state;
    frame_state_t state_nx;
    logic [2:0]   cnt;
    logic [2:0]   cnt_nx;
    logic [7:0]   shift;
    logic [7:0]   shift_nx;
    logic         par;
    logic         par_nx;
    logic [TW-1:0] timer;

    assign fall    = clk_prev & ~clk_sync[1];
    assign din     = data_sync[1];
    assign timeout = (state != IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign rx_byte = shift;

    // Two-flop synchronisers (reset to bus-idle high) plus previous-clock tap for edge detect
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    // Frame state, bit counter, shift register and parity capture
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            shift <= '0;
            par   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            shift <= shift_nx;
            par   <= par_nx;
        end
    end

    // Inter-edge timer: restarts on each falling edge, idle outside a frame
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            timer <= '0;
        else
            timer <= (fall || state == IDLE) ? '0 : timer + TW'(1);
    end

    // Next-state logic; byte_valid/byte_err are combinational on the stop-bit edge cycle
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        shift_nx   = shift;
        par_nx     = par;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        if (timeout) begin
            state_nx = IDLE;
            byte_err = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!din) begin
                        state_nx = DATA;
                        cnt_nx   = '0;
                    end
                end
                DATA: begin
                    shift_nx = {din, shift[7:1]};
                    cnt_nx   = cnt + 3'd1;
                    if (cnt == 3'd7)
                        state_nx = PARITY;
                end
                PARITY: begin
                    par_nx   = din;
                    state_nx = STOP;
                end
                STOP: begin
                    state_nx   = IDLE;
                    byte_valid = din & (^{shift, par});
                    byte_err   = ~(din & (^{shift, par}));
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: assembles E0/F0 prefixes and received bytes into scancodes
module ps2_scancode_rx
    import ps2_scancode_rx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] scancode,
    output logic        brk,
    output logic        scancode_valid,
    output logic        frame_err
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       byte_err;
    logic       ext;
    logic       brk_pend;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .clk       (clk),
        .resetn    (resetn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .byte_err  (byte_err)
    );

    // Prefix flags collect E0/F0; any other byte publishes a code and clears them, errors clear them too
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ext            <= 1'b0;
            brk_pend       <= 1'b0;
            scancode       <= '0;
            brk            <= 1'b0;
            scancode_valid <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            scancode_valid <= 1'b0;
            frame_err      <= byte_err;
            if (byte_err) begin
                ext      <= 1'b0;
                brk_pend <= 1'b0;
            end else if (byte_valid) begin
                if (rx_byte == PS2_EXT)
                    ext <= 1'b1;
                else if (rx_byte == PS2_BRK)
                    brk_pend <= 1'b1;
                else begin
                    scancode       <= {ext ? PS2_EXT : 8'h00, rx_byte};
                    brk            <= brk_pend;
                    scancode_valid <= 1'b1;
                    ext            <= 1'b0;
                    brk_pend       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 5000, meaning clk cycles without a PS/2 falling edge before a partial frame is aborted (100 us at 50 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ps2_clk  input  1  raw PS/2 clock, asynchronous to clk.
REQ-005 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-006 SHALL have port scancode  output  16  last complete code: {8'hE0 or 8'h00, code byte}.
REQ-007 SHALL have port brk  output  1  1 = last code was a break (release), 0 = make.
REQ-008 SHALL have port scancode_valid  output  1  one-cycle pulse when scancode/brk update.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error.
REQ-010 SHALL use one clock (clk); reset is asynchronous, active-low (resetn).

Function
REQ-011 SHALL synchronise ps2_clk and ps2_data through two flip-flops each before use.
REQ-012 SHALL detect a PS/2 falling edge as synchronised ps2_clk previous=1, current=0; all bit sampling SHALL occur only on such a cycle.
REQ-013 Frame FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: edge with data=0 -> DATA, bit count cleared; edge with data=1 -> stay IDLE, no error.
REQ-015 DATA: shift data in LSB first; after the 8th bit -> PARITY.
REQ-016 PARITY: capture bit; -> STOP.
REQ-017 STOP: edge with data=1 and odd parity over 8 data + parity bit -> byte accepted, IDLE; else frame_err pulse, byte discarded, IDLE.
REQ-018 Bit timer SHALL reset on every falling edge; in DATA/PARITY/STOP reaching TIMEOUT_CYCLES SHALL pulse frame_err and return to IDLE; timer inactive in IDLE.
REQ-019 Accepted byte 8'hE0 SHALL set ext flag; 8'hF0 SHALL set brk_pend flag; neither produces scancode_valid.
REQ-020 Any other accepted byte SHALL load scancode={ext?8'hE0:8'h00, byte}, brk=brk_pend, pulse scancode_valid, then clear ext and brk_pend.
REQ-021 scancode_valid SHALL assert on the clk cycle after the cycle on which the stop-bit edge is detected (1-cycle latency).
REQ-022 Any frame_err SHALL clear ext and brk_pend.
REQ-023 scancode and brk SHALL hold their values between valid pulses.
REQ-024 scancode_valid and frame_err SHALL never assert on the same cycle.
REQ-025 Repeated E0 or F0 prefixes SHALL be idempotent (flags stay set).

Reset
REQ-026 On resetn=0: FSM IDLE, bit count 0, timer 0, ext=0, brk_pend=0, scancode=16'h0000, brk=0, scancode_valid=0, frame_err=0, synchroniser flops=1 (bus idle).
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no valid or error pulse after release.

Structure
REQ-028 Shared package SHALL hold frame-state enum, constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, and the frame length (11).
REQ-029 Bit-level receive (sync, edge detect, FSM, timer, parity) SHALL be sub-module ps2_frame_rx emitting byte + byte_valid + byte_err; ps2_scancode_rx SHALL hold prefix assembly and outputs.

Verification
REQ-030 Frames 8'hE0, 8'h6B -> single valid pulse, scancode=16'hE06B, brk=0.
REQ-031 Frames 8'hE0, 8'hF0, 8'h75 -> scancode=16'hE075, brk=1; then 8'h1C -> scancode=16'h001C, brk=0.
REQ-032 Frame 8'h72 with wrong parity -> frame_err pulse, no valid, scancode unchanged; next 8'h72 good -> scancode=16'h0072.
REQ-033 E0 frame, then 4 bits of next frame and ps2_clk held high TIMEOUT_CYCLES -> frame_err pulse; next 8'h74 -> scancode=16'h0074 (ext cleared).
REQ-034 resetn pulsed low after 5 data bits -> all outputs 0; following full 8'h6B frame -> scancode=16'h006B, exactly one valid.
REQ-035 Stop bit driven 0 on 8'h6B -> frame_err pulse, no valid.
